// File: rtl/shift_result_stage.sv
// shift_result_stage
// Registered output stage behind the 32-bit barrel left shifter. It captures the
// shifter result and derives the zero, negative and carry-out flags. A 2-entry
// skid buffer holds them behind a valid/ready handshake, so a writeback stall
// never loses or repeats a result.

module shift_result_stage #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_zero,
  output logic               out_neg,
  output logic               out_carry,
  output logic [CNT_W-1:0]   out_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q;
  logic                inReady_q;
  logic                outValid_q;

  logic [DATA_W-1:0]   mResult_q;
  logic                mZero_q;
  logic                mNeg_q;
  logic                mCarry_q;

  logic [DATA_W-1:0]   sResult_q;
  logic                sZero_q;
  logic                sNeg_q;
  logic                sCarry_q;

  logic [CNT_W-1:0]    count_q;

  logic                accept;
  logic                deliver;
  logic [SHAMT_W-1:0]  carryIdx;
  logic                newZero;
  logic                newNeg;
  logic                newCarry;

  // Handshake events and the flags for the incoming entry. The carry is the last
  // bit of a pushed out of the word. That bit sits at index DATA_W - shamt.
  // DATA_W is a power of two, so this index equals -shamt modulo DATA_W.
  // A zero shift leaves no bit shifted out, so the flag is forced low in that case.
  always_comb begin
    accept   = in_valid & inReady_q;
    deliver  = outValid_q & out_ready;
    carryIdx = SHAMT_W'(DATA_W) - in_shamt;
    newZero  = (in_result == '0);
    newNeg   = in_result[DATA_W-1];
    newCarry = (in_shamt == '0) ? 1'b0 : in_a[carryIdx];
  end

  // Skid-buffer state machine. M drives the outputs and S catches the entry that
  // arrives while M is stalled. in_ready is registered from the next state, so it
  // never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      mResult_q  <= '0;
      mZero_q    <= 1'b0;
      mNeg_q     <= 1'b0;
      mCarry_q   <= 1'b0;
      sResult_q  <= '0;
      sZero_q    <= 1'b0;
      sNeg_q     <= 1'b0;
      sCarry_q   <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            mResult_q  <= in_result;
            mZero_q    <= newZero;
            mNeg_q     <= newNeg;
            mCarry_q   <= newCarry;
            state_q    <= ONE;
            outValid_q <= 1'b1;
            inReady_q  <= 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            mResult_q <= in_result;
            mZero_q   <= newZero;
            mNeg_q    <= newNeg;
            mCarry_q  <= newCarry;
          end else if (accept) begin
            sResult_q <= in_result;
            sZero_q   <= newZero;
            sNeg_q    <= newNeg;
            sCarry_q  <= newCarry;
            state_q   <= FULL;
            inReady_q <= 1'b0;
          end else if (deliver) begin
            state_q    <= EMPTY;
            outValid_q <= 1'b0;
          end
        end
        FULL: begin
          if (deliver) begin
            mResult_q <= sResult_q;
            mZero_q   <= sZero_q;
            mNeg_q    <= sNeg_q;
            mCarry_q  <= sCarry_q;
            state_q   <= ONE;
            inReady_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  // Count completed output handshakes. The counter wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (deliver) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign in_ready   = inReady_q;
  assign out_valid  = outValid_q;
  assign out_result = mResult_q;
  assign out_zero   = mZero_q;
  assign out_neg    = mNeg_q;
  assign out_carry  = mCarry_q;
  assign out_count  = count_q;

endmodule
